// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) that stalls the pipeline and returns remainder on hi, quotient on lo.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and completes in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall_div,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quot, dvsr;
  logic             q_neg, r_neg, dz;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] rem_nxt, quot_nxt, hi_fix, lo_fix;

  assign a_mag = (signed_div && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_div && b[WIDTH-1]) ? -b : b;

  assign stall_div = ((state == IDLE) && start && !annul) || ((state == DIV) && !annul);

  // One restoring step. When the shifted-out remainder MSB is set the shifted value
  // already exceeds any divisor, which the (WIDTH+1)-bit difference cannot show by itself.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    diff     = {rem, quot[WIDTH-1]} - {1'b0, dvsr};
    take     = rem[WIDTH-1] | ~diff[WIDTH];
    rem_nxt  = take ? diff[WIDTH-1:0] : {rem[WIDTH-2:0], quot[WIDTH-1]};
    quot_nxt = {quot[WIDTH-2:0], take};
    // A zero divisor leaves |a| in the remainder; re-applying the dividend sign yields raw a.
    hi_fix   = r_neg ? -rem_nxt : rem_nxt;
    lo_fix   = dz ? '1 : (q_neg ? -quot_nxt : quot_nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      ready <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      rem   <= '0;
      quot  <= '0;
      dvsr  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start && !annul) begin
            rem   <= '0;
            quot  <= a_mag;
            dvsr  <= b_mag;
            q_neg <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg <= signed_div & a[WIDTH-1];
            dz    <= (b == '0);
            cnt   <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (b == '0) begin
              hi    <= a;
              lo    <= '1;
              ready <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= DIV;
            end
`else
            busy  <= 1'b1;
            state <= DIV;
`endif
          end
        end
        DIV: begin
          if (annul) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem  <= rem_nxt;
            quot <= quot_nxt;
            cnt  <= cnt + CW'(1);
            if (cnt == LAST) begin
              hi    <= hi_fix;
              lo    <= lo_fix;
              busy  <= 1'b0;
              ready <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus queues expected hi/lo/ready-cycle, a negedge monitor checks each ready pulse.
module tb_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;
`ifdef DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = W + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start, signed_div, annul;
  logic [W-1:0]  a, b;
  logic          stall_div, busy, ready;
  logic [W-1:0]  hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .a(a), .b(b), .stall_div(stall_div), .busy(busy), .ready(ready), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && ready) begin
      if (sb.size() == 0) begin
        check1("spurious_ready", ready, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("ready_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Called #1 after a rising edge in an IDLE cycle; returns #1 after the next edge.
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic s,
                        input logic [31:0] eh, input logic [31:0] el, input int lat,
                        input logic expect_result);
    a = av; b = bv; signed_div = s; start = 1'b1;
    if (expect_result) sb.push_back('{eh, el, cyc + lat});
    #1;
    check1("stall_at_start", stall_div, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Walks cycles 1..lat of an operation; optional annul or stray start at a given cycle.
  task automatic wait_done(input int lat, input int annul_at, input int poke_at);
    for (int i = 1; i < lat; i++) begin
      if (i == annul_at) begin
        annul = 1'b1;
        #1;
        check1("stall_during_annul", stall_div, 1'b0);
        @(posedge clk); #1;
        annul = 1'b0;
        check1("busy_after_annul", busy, 1'b0);
        return;
      end
      if (i == poke_at) begin
        start = 1'b1; a = 32'd10; b = 32'd3; signed_div = 1'b0;
      end
      check1("stall_in_div", stall_div, 1'b1);
      check1("busy_in_div", busy, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    check1("stall_in_done", stall_div, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check1("reset_busy", busy, 1'b0);
    check1("reset_ready", ready, 1'b0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check1("idle_stall", stall_div, 1'b0);

    // Basic unsigned, signed and boundary vectors.
    launch(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, LAT, 1'b1);                    wait_done(LAT, -1, -1);
    launch(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT, 1'b1); wait_done(LAT, -1, -1);
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, LAT, 1'b1); wait_done(LAT, -1, -1);
    launch(32'hFFFF_FFFF, 32'h10, 1'b0, 32'hF, 32'h0FFF_FFFF, LAT, 1'b1);       wait_done(LAT, -1, -1);
    launch(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, LAT, 1'b1);        wait_done(LAT, -1, -1);
    launch(32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 32'hFFFF_FFFF, LAT, 1'b1);        wait_done(LAT, -1, -1);

    // Divide by zero, unsigned and signed: lo all ones, hi raw dividend.
    launch(32'h1234, 32'h0, 1'b0, 32'h1234, 32'hFFFF_FFFF, DZ_LAT, 1'b1);       wait_done(DZ_LAT, -1, -1);
    launch(32'hFFFF_FFF9, 32'h0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, DZ_LAT, 1'b1); wait_done(DZ_LAT, -1, -1);

    // Annul at cycle 10: no result, hi/lo retained, new start in cycle 11 completes.
    launch(32'd1000, 32'd10, 1'b0, 32'h0, 32'h0, LAT, 1'b0);
    wait_done(LAT, 10, -1);
    check("hi_kept_after_annul", hi, 32'hFFFF_FFF9);
    check("lo_kept_after_annul", lo, 32'hFFFF_FFFF);
    launch(32'd50, 32'd3, 1'b0, 32'd2, 32'd16, LAT, 1'b1);                      wait_done(LAT, -1, -1);

    // Stray start at cycle 5 must be ignored.
    launch(32'd81, 32'd9, 1'b0, 32'd0, 32'd9, LAT, 1'b1);                       wait_done(LAT, -1, 5);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset at cycle 20 of an operation.
    launch(32'd20, 32'd4, 1'b0, 32'h0, 32'h0, LAT, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check1("midop_reset_busy", busy, 1'b0);
    check1("midop_reset_ready", ready, 1'b0);
    check1("midop_reset_stall", stall_div, 1'b0);
    check("midop_reset_hi", hi, 32'h0);
    check("midop_reset_lo", lo, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    launch(32'd9, 32'd2, 1'b0, 32'd1, 32'd4, LAT, 1'b1);                        wait_done(LAT, -1, -1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit radix-2 divider that is the responder to the pipeline controller's divide stall and HI/LO write path. It accepts a DIV/DIVU operation from the execute stage and holds `stall_div` high while it iterates. It then presents a one-cycle `ready` pulse with the remainder on `hi` and the quotient on `lo` for the HI/LO register write.

## Interface
- `WIDTH`, default 32: operand width; `hi`/`lo` are each `WIDTH` bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request a divide; sampled only in IDLE.
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU; captured with `start`.
- `annul` in 1: cancel the in-flight operation (pipeline flush).
- `a` in `WIDTH`: dividend; captured with `start`.
- `b` in `WIDTH`: divisor; captured with `start`.
- `stall_div` out 1: combinational; hold the pipeline.
- `busy` out 1: registered; high in DIV state.
- `ready` out 1: registered; one-cycle result-valid pulse (DONE state).
- `hi` out `WIDTH`: remainder.
- `lo` out `WIDTH`: quotient.

## Operation
- States: IDLE, DIV, DONE. Reset: IDLE, `busy`=0, `ready`=0, `hi`=`lo`=0, counter=0.
- IDLE, `start`=1, `annul`=0:
  - Capture the operands.
  - For `signed_div`=1, convert to magnitudes. Latch the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)).
  - Clear the partial remainder. Set counter=0. Go to DIV.
- DIV:
  - Each cycle runs one restoring step: shift {rem, quot} left 1, subtract the divisor magnitude from rem, and keep the result if it is non-negative (quot bit = 1); otherwise restore.
  - The subtractor is `WIDTH`+1 bits wide.
  - The counter increments each step. After step `WIDTH`-1 (counter = `WIDTH`-1), go to DONE and load the sign-corrected results into `hi`/`lo`.
- DONE: `ready`=1 for exactly one cycle, then IDLE unconditionally.
- Sign fix:
  - Negate the quotient if the quotient sign is 1.
  - Negate the remainder if the dividend was negative.
  - 0x80000000 / 0xFFFFFFFF (signed) gives `lo`=0x80000000, `hi`=0 (wraps, no trap).
- Divide by zero (`b`=0): runs the full latency. Result is `lo`=all ones and `hi`=`a` (raw dividend), for both signed and unsigned.
- `hi`/`lo` hold their last result until the next DONE load. They are not cleared by `start` or `annul`.
- `start` during DIV or DONE is ignored (no queueing).
- `annul`:
  - In DIV or DONE: next state is IDLE, `ready` is not asserted (or is dropped), and `hi`/`lo` are unchanged.
  - In IDLE together with `start`: `annul` wins, nothing is captured.
- `rst` low mid-operation: immediate return to the reset state, asynchronously.

## Timing
- Cycle 0: `start` high in IDLE. `stall_div`=1 combinationally in this same cycle.
- Cycles 1..`WIDTH`: DIV. `busy`=1, `stall_div`=1.
- Cycle `WIDTH`+1: DONE. `ready`=1, `hi`/`lo` valid, `stall_div`=0 so the pipeline advances and writes HI/LO on this edge.
- Total: `ready` arrives `WIDTH`+1 cycles after the start cycle (33 for `WIDTH`=32).
- `stall_div` = (IDLE & `start` & ~`annul`) | (state==DIV & ~`annul`).
- The earliest next accepted `start` is the cycle after DONE.

## Configuration
- `DIV_ZERO_FAST_EN`:
  - Defined: `b`=0 captured in IDLE skips DIV and goes straight to DONE. `ready` comes in cycle 1, with the same divide-by-zero result values, and `stall_div` is high in cycle 0 only.
  - Undefined: divide by zero takes the full `WIDTH`+1-cycle latency.
- Non-zero divisors behave identically either way.

## Test plan
- DIVU: `a`=100, `b`=7 -> `ready` in cycle 33, `lo`=14, `hi`=2, `stall_div` high for cycles 0..32.
- DIV: `a`=-7 (0xFFFFFFF9), `b`=2 -> `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1). Also 0x80000000 / -1 -> `lo`=0x80000000, `hi`=0.
- `b`=0, `a`=0x1234:
  - Without the macro: `ready` in cycle 33, `lo`=0xFFFFFFFF, `hi`=0x1234.
  - With `DIV_ZERO_FAST_EN`: `ready` in cycle 1, same values.
- `annul` in cycle 10 of a divide -> IDLE in cycle 11, no `ready`, `hi`/`lo` keep the prior result. A new `start` in cycle 11 completes normally.
- `start` pulsed at cycle 5 while busy -> ignored: exactly one `ready`, at cycle 33, with the first operands' result.
- `rst` asserted low at cycle 20 -> `busy`/`ready`/`hi`/`lo` go to 0 immediately; after release, IDLE accepts `start`.
